// File: rtl/fir_sample_feeder.sv
// rtl/fir_sample_feeder.sv - buffered, tick-paced sample feeder for the FIR input
module fir_sample_feeder #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 8,
  parameter int TICK_DIV    = 4,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                        system1000,
  input  logic                        system1000_rstn,
  input  logic                        enable,
  input  logic                        flush,
  input  logic signed [DATA_W-1:0]    in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [DATA_W-1:0]    sample_out,
  output logic                        sample_strobe,
  output logic                        underrun,
  input  logic                        underrun_clr,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN
  } state_t;

  state_t                    state;
  logic [CW-1:0]             tick_cnt;
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic signed [DATA_W-1:0]  mem [DEPTH];

  logic push;
  logic pop;
  logic tick;
  logic fifo_empty;

  // Acceptance depends only on occupancy and flush, never on in_valid.
  assign in_ready   = (level != FULL_LVL) && !flush;
  assign push       = in_valid && in_ready;
  assign fifo_empty = (level == '0);

  // A tick is suppressed on the cycle RUN is being left (enable low or flush).
  assign tick = (state == ST_RUN) && enable && !flush && (tick_cnt == TICK_LAST);
  assign pop  = tick && !fifo_empty;

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge system1000) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Control FSM with tick counter and registered output stream.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state         <= ST_IDLE;
      tick_cnt      <= '0;
      sample_out    <= '0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      sample_strobe <= tick;

      if (tick) begin
        sample_out <= fifo_empty ? '0 : mem[rd_ptr];
      end

      if (tick && fifo_empty) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          tick_cnt <= '0;
          if (enable) begin
            state <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          tick_cnt <= '0;
          if (!enable) begin
            state <= ST_IDLE;
          end else if (!flush && (level >= PRIME_LVL)) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
          end else if (flush) begin
            state    <= ST_PRIME;
            tick_cnt <= '0;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
          end else begin
            tick_cnt <= tick_cnt + CW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb/tb_fir_sample_feeder.sv - directed self-checking bench for fir_sample_feeder
module tb_fir_sample_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic               enable, flush, in_valid, underrun_clr;
  logic signed [15:0] in_data;
  logic               in_ready, sample_strobe, underrun;
  logic signed [15:0] sample_out;
  logic [3:0]         level;

  logic               enable_b, flush_b, in_valid_b, underrun_clr_b;
  logic signed [15:0] in_data_b;
  logic               in_ready_b, sample_strobe_b, underrun_b;
  logic signed [15:0] sample_out_b;
  logic [3:0]         level_b;

  fir_sample_feeder #(.DATA_W(16), .DEPTH(8), .TICK_DIV(4), .PRIME_LEVEL(4)) u_dut (
    .system1000      (clk),
    .system1000_rstn (rst_n),
    .enable          (enable),
    .flush           (flush),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .sample_out      (sample_out),
    .sample_strobe   (sample_strobe),
    .underrun        (underrun),
    .underrun_clr    (underrun_clr),
    .level           (level)
  );

  fir_sample_feeder #(.DATA_W(16), .DEPTH(8), .TICK_DIV(1), .PRIME_LEVEL(4)) u_dut_b (
    .system1000      (clk),
    .system1000_rstn (rst_n),
    .enable          (enable_b),
    .flush           (flush_b),
    .in_data         (in_data_b),
    .in_valid        (in_valid_b),
    .in_ready        (in_ready_b),
    .sample_out      (sample_out_b),
    .sample_strobe   (sample_strobe_b),
    .underrun        (underrun_b),
    .underrun_clr    (underrun_clr_b),
    .level           (level_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic idle_inputs();
    enable = 0; flush = 0; in_valid = 0; underrun_clr = 0; in_data = '0;
    enable_b = 0; flush_b = 0; in_valid_b = 0; underrun_clr_b = 0; in_data_b = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bvals [6];
    int k, idx, acc, nxt, found, seen;

    // ---------------- reset state ----------------
    idle_inputs();
    rst_n = 0;
    #12;
    check_eq("rst_sample_out", sample_out, 0);
    check_eq("rst_strobe", sample_strobe, 0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // ---------------- basic stream ----------------
    do_reset();
    bvals = '{100, -200, 300, -400, 5, 6};
    enable = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      in_data  = 16'(bvals[i]);
      step();
      if (i == 3) check_eq("basic_level4", level, 4);
    end
    in_valid = 0;
    check_eq("basic_level6", level, 6);
    k = 0;
    while (cyc < 31) begin
      step();
      if (sample_strobe) begin
        if (k < 6) begin
          check_eq("basic_val", sample_out, bvals[k]);
          check_eq("basic_cyc", cyc, 9 + 4 * k);
        end
        k++;
      end
    end
    check_eq("basic_count", k, 6);

    // ---------------- underrun ----------------
    do_reset();
    enable = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1;
      in_data  = 16'(i);
      step();
    end
    in_valid = 0;
    step_to(21);
    check_eq("ur_last_val", sample_out, 4);
    check_eq("ur_last_strobe", sample_strobe, 1);
    check_eq("ur_not_yet", underrun, 0);
    step_to(25);
    check_eq("ur_zero_val", sample_out, 0);
    check_eq("ur_zero_strobe", sample_strobe, 1);
    check_eq("ur_set", underrun, 1);
    underrun_clr = 1;
    step();
    underrun_clr = 0;
    check_eq("ur_cleared", underrun, 0);
    step_to(29);
    check_eq("ur_reset_again", underrun, 1);
    underrun_clr = 1;
    step();
    check_eq("ur_clr2", underrun, 0);
    step_to(32);
    check_eq("ur_clr_held", underrun, 0);
    step();
    check_eq("ur_set_wins", underrun, 1);
    check_eq("ur_set_wins_strobe", sample_strobe, 1);
    underrun_clr = 0;

    // ---------------- backpressure ----------------
    do_reset();
    enable = 0;
    idx = 0;
    in_valid = 1;
    in_data = 16'(10);
    for (int t = 0; t < 12 && idx < 8; t++) begin
      acc = in_ready;
      step();
      if (acc) idx++;
      in_data = 16'(10 + idx);
    end
    check_eq("bp_accepts", idx, 8);
    check_eq("bp_full_level", level, 8);
    check_eq("bp_not_ready", in_ready, 0);
    step();
    step();
    check_eq("bp_hold_level", level, 8);
    enable = 1;
    k = 0;
    for (int t = 0; t < 40; t++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        idx++;
        in_valid = 0;
        check_eq("bp_refill_level", level, 8);
      end
      if (sample_strobe) begin
        check_eq("bp_order", sample_out, 10 + k);
        k++;
      end
    end
    check_eq("bp_ninth_accepted", idx, 9);
    check_eq("bp_pop_count", k, 9);
    check_eq("bp_no_underrun", underrun, 0);

    // ---------------- push/pop collision with wrap ----------------
    do_reset();
    enable_b = 1;
    in_valid_b = 1;
    nxt = 0;
    in_data_b = 16'(0);
    k = 0;
    for (int t = 0; t < 40; t++) begin
      acc = in_ready_b;
      step();
      if (acc) nxt++;
      in_data_b = 16'(nxt);
      if (cyc >= 5) check_eq("col_level", level_b, 5);
      if (sample_strobe_b && k < 20) begin
        check_eq("col_val", sample_out_b, k);
        k++;
      end
    end
    check_eq("col_count", k, 20);
    in_valid_b = 0;
    enable_b = 0;

    // ---------------- flush mid-run ----------------
    do_reset();
    enable = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      in_data  = 16'(21 + i);
      step();
    end
    in_valid = 0;
    step_to(9);
    check_eq("fl_first_strobe", sample_strobe, 1);
    check_eq("fl_first_val", sample_out, 21);
    check_eq("fl_level5", level, 5);
    step();
    flush = 1;
    in_valid = 1;
    in_data = 16'(77);
    #1;
    check_eq("fl_in_ready", in_ready, 0);
    step();
    flush = 0;
    in_valid = 0;
    check_eq("fl_level0", level, 0);
    check_eq("fl_hold_out", sample_out, 21);
    seen = 0;
    for (int t = 0; t < 12; t++) begin
      step();
      if (sample_strobe) seen++;
    end
    check_eq("fl_no_strobe", seen, 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data  = 16'(41 + i);
      step();
      if (sample_strobe) seen++;
    end
    in_valid = 0;
    check_eq("fl_no_strobe_prime", seen, 0);
    found = 0;
    for (int t = 0; t < 20 && found == 0; t++) begin
      step();
      if (sample_strobe) begin
        found = 1;
        check_eq("fl_resume_val", sample_out, 41);
      end
    end
    check_eq("fl_resume_found", found, 1);

    // ---------------- async reset mid-period ----------------
    do_reset();
    enable = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data  = 16'(31 + i);
      step();
    end
    in_valid = 0;
    step_to(11);
    check_eq("ar_pre_level", level, 3);
    check_eq("ar_pre_out", sample_out, 31);
    #2;
    rst_n = 0;
    #1;
    check_eq("ar_out0", sample_out, 0);
    check_eq("ar_level0", level, 0);
    check_eq("ar_strobe0", sample_strobe, 0);
    check_eq("ar_underrun0", underrun, 0);
    check_eq("ar_in_ready", in_ready, 1);
    enable = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc = 0;
    check_eq("ar_in_ready_rel", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data  = 16'(51 + i);
      step();
      if (sample_strobe) seen++;
    end
    in_valid = 0;
    for (int t = 0; t < 12; t++) begin
      step();
      if (sample_strobe) seen++;
    end
    check_eq("ar_idle_no_strobe", seen, 0);
    check_eq("ar_idle_level", level, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
Transmit-side companion to the FIR filter top entity. It accepts 16-bit signed samples from an upstream producer over a valid/ready handshake and buffers them in a small FIFO. It presents one sample per sample period on a registered output that drives the FIR input directly. Underrun is handled by zero-stuffing and a sticky flag; a priming state stops the first pops from immediately underrunning the FIFO.

Parameters:
DATA_W, 16, sample width (signed), matches the FIR input width
DEPTH, 8, FIFO depth in samples (power of two, >=2)
TICK_DIV, 4, clocks per sample period (>=1; 1 = one sample every clock)
PRIME_LEVEL, 4, FIFO occupancy required to leave PRIME (1..DEPTH)

Ports:
system1000  input  1  clock
system1000_rstn  input  1  asynchronous reset, active low
enable  input  1  run request; low = halt output stream
flush  input  1  synchronous FIFO clear, one-cycle pulse
in_data  input  DATA_W  signed sample from producer
in_valid  input  1  producer has sample
in_ready  output  1  FIFO can accept (not full)
sample_out  output  DATA_W  signed sample to FIR input, registered
sample_strobe  output  1  one-cycle pulse when sample_out updates at a tick
underrun  output  1  sticky: a tick found the FIFO empty in RUN
underrun_clr  input  1  clears underrun
level  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, active low): FIFO empty, level=0, state=IDLE, tick counter=0, sample_out=0, sample_strobe=0, underrun=0. in_ready=1 after reset.
- Push rule: push occurs when in_valid & in_ready. in_ready = (level != DEPTH) & !flush. It is combinational from state only, never from in_valid.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps, only in RUN. It is held at 0 in IDLE and PRIME.
  - A tick is the cycle the counter equals TICK_DIV-1; with TICK_DIV=1, every RUN cycle is a tick.
- State machine:
  - IDLE: no pops. sample_out holds its last value. Go to PRIME when enable=1.
  - PRIME: no pops. Go to RUN when level >= PRIME_LEVEL; go to IDLE if enable=0.
  - RUN: on each tick, pop the FIFO head into sample_out and pulse sample_strobe. If the FIFO is empty at the tick: sample_out<=0, sample_strobe still pulses, underrun<=1, stay in RUN (no re-prime). Go to IDLE if enable=0; counter resets to 0 and no pop happens that cycle.
- Latency: the first pop occurs TICK_DIV cycles after entering RUN. A sample written into an empty FIFO in cycle t is visible at the earliest on the tick at or after t+1 (no same-cycle bypass).
- Simultaneous push+pop: level unchanged; the popped value is the old head. When full, push is blocked because in_ready=0, while a pop on that cycle still happens.
- Wrap-around: read and write pointers wrap modulo DEPTH. level distinguishes full from empty.
- flush=1: FIFO emptied, level=0 next cycle, and any push on that cycle is discarded (in_ready=0). If in RUN, return to PRIME and reset the counter. sample_out holds its value and underrun is unaffected.
- underrun_clr: clears underrun next cycle. If an underrun tick coincides with it, set wins (underrun=1).
- Arithmetic: data passes through unmodified (no rounding or sign change). Zero-stuff value is signed 0.
- Reset asserted mid-stream: all state is cleared immediately and asynchronously; any partial sample period is discarded.

Test Plan:
- Basic stream: TICK_DIV=4, PRIME_LEVEL=4, enable=1, push 100,-200,300,-400,5,6 back to back -> RUN entered after level reaches 4. sample_out=100,-200,300,-400,5,6 on successive ticks 4 clocks apart, with one sample_strobe per tick.
- Backpressure: hold enable=0 and push 9 samples with DEPTH=8 -> in_ready drops after the 8th accept and level=8. The 9th is held by the producer and accepted after the first pop once enabled.
- Underrun: prime with 4 samples and stop pushing -> after 4 ticks, the 5th tick gives sample_out=0, strobe=1, underrun=1. Pulse underrun_clr -> underrun=0; on coincident underrun tick and clr -> underrun=1.
- Push/pop collision: TICK_DIV=1 with a steady 1 push per clock in RUN -> level stays constant and output order is preserved across pointer wrap (≥20 samples, counting values 0..19).
- Flush mid-run: in RUN with level=5, assert flush with in_valid=1 -> level=0, the pushed sample is dropped, state=PRIME, and no strobe until PRIME_LEVEL is reached again.
- Async reset mid-period: assert system1000_rstn=0 between clock edges with counter=2 and level=3 -> all outputs go to 0 immediately. After release, in_ready=1 and state=IDLE.
